// File: rtl/bus_data_responder_if.sv
// bus_data_responder_if: data-bus signals between the RV32I core (master) and the data responder (slave)
interface bus_data_responder_if;
  logic        busWe;
  logic        busRe;
  logic [2:0]  busSize;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        busErr;
  logic        timerIrq;
  modport master(output busWe, busRe, busSize, busAddr, busWData, input busRData, busErr, timerIrq);
  modport slave(input busWe, busRe, busSize, busAddr, busWData, output busRData, busErr, timerIrq);
endinterface

// File: rtl/bus_data_responder.sv
// bus_data_responder: word-organised data RAM plus memory-mapped timer on the core's data bus.
// Optional TIMER_PRESCALE_EN adds a 16-bit PRESC register at TIMER_BASE+0x10.
module bus_data_responder #(
  parameter int          RAM_WORDS  = 256,
  parameter logic [31:0] TIMER_BASE = 32'h1000_0000
) (
  input logic clk,
  input logic reset,
  bus_data_responder_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  logic [31:0] mem [RAM_WORDS];
  logic [2:0]  ctrl;
  logic [31:0] count, cmp;
  logic        match;
  logic [31:0] a, d, word, ram_rd, tmr_rd, wd;
  logic [2:0]  sz;
  logic [3:0]  be;
  logic [7:0]  b;
  logic [15:0] h;
  logic        ram_hit, tmr_hit, presc_hit, mis, bad_sz, fault, wr, tick, eq;
  logic        wr_ctrl, wr_count, wr_cmp, wr_stat;
  assign a  = bus.busAddr;
  assign d  = bus.busWData;
  assign sz = bus.busSize;
`ifdef TIMER_PRESCALE_EN
  logic [15:0] presc, pcnt;
  logic        wr_presc;
  assign presc_hit = a[31:2] == 30'((TIMER_BASE + 32'h10) >> 2);
  assign tick      = ctrl[0] & (pcnt == presc);
  assign wr_presc  = wr & presc_hit;
`else
  assign presc_hit = 1'b0;
  assign tick      = ctrl[0];
`endif
  always_comb begin
    ram_hit = a < RAM_BYTES;
    tmr_hit = (a[31:4] == TIMER_BASE[31:4]) | presc_hit;
    mis     = ((sz[1:0] == 2'b01) & a[0]) | ((sz[1:0] == 2'b10) & (|a[1:0]));
    bad_sz  = (sz == 3'b011) | (sz[2:1] == 2'b11);
    fault   = mis | bad_sz | !(ram_hit | tmr_hit) | (tmr_hit & (sz != 3'b010));
    wr      = bus.busWe & !fault;
    word    = mem[a[AW+1:2]];
    b       = 8'(word >> {a[1:0], 3'b000});
    h       = a[1] ? word[31:16] : word[15:0];
    ram_rd  = (sz[1:0] == 2'b00) ? {{24{b[7] & ~sz[2]}}, b} :
              (sz[1:0] == 2'b01) ? {{16{h[15] & ~sz[2]}}, h} : word;
    tmr_rd  = (a[3:2] == 2'd0) ? {29'd0, ctrl} :
              (a[3:2] == 2'd1) ? count :
              (a[3:2] == 2'd2) ? cmp : {31'd0, match};
`ifdef TIMER_PRESCALE_EN
    if (presc_hit) tmr_rd = {16'd0, presc};
`endif
    wd       = (sz[1:0] == 2'b00) ? {4{d[7:0]}} : (sz[1:0] == 2'b01) ? {2{d[15:0]}} : d;
    be       = (sz[1:0] == 2'b00) ? 4'b0001 << a[1:0] :
               (sz[1:0] == 2'b01) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    eq       = count == cmp;
    wr_ctrl  = wr & tmr_hit & !presc_hit & (a[3:2] == 2'd0);
    wr_count = wr & tmr_hit & !presc_hit & (a[3:2] == 2'd1);
    wr_cmp   = wr & tmr_hit & !presc_hit & (a[3:2] == 2'd2);
    wr_stat  = wr & tmr_hit & !presc_hit & (a[3:2] == 2'd3);
  end
  assign bus.busRData = fault ? 32'd0 : ram_hit ? ram_rd : tmr_rd;
  assign bus.busErr   = (bus.busWe | bus.busRe) & fault;
  assign bus.timerIrq = match & ctrl[2];
  always_ff @(posedge clk)
    if (wr & ram_hit)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[a[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
  // Match is judged on the pre-write COUNT; a CPU write to COUNT overrides the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl  <= 3'd0;
      count <= 32'd0;
      cmp   <= 32'd0;
      match <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      presc <= 16'd0;
      pcnt  <= 16'd0;
`endif
    end else begin
      if (tick & eq) match <= 1'b1;
      else if (wr_stat & d[0]) match <= 1'b0;
      if (wr_count) count <= d;
      else if (tick) count <= (eq & ctrl[1]) ? 32'd0 : count + 32'd1;
      if (wr_ctrl) ctrl <= d[2:0];
      if (wr_cmp) cmp <= d;
`ifdef TIMER_PRESCALE_EN
      if (wr_presc) presc <= d[15:0];
      if (wr_ctrl & !d[0]) pcnt <= 16'd0;
      else if (ctrl[0]) pcnt <= tick ? 16'd0 : pcnt + 16'd1;
`endif
    end
  end
endmodule

// File: tb/tb_bus_data_responder.sv
// tb_bus_data_responder: scoreboard bench; each step is queued with its expected response and
// checked when the DUT presents it (one bus step per clock, driven on the falling edge).
module tb_bus_data_responder;
  localparam logic [31:0] TB = 32'h1000_0000;
  localparam logic [31:0] CTRL = TB, COUNT = TB + 32'h4, CMP = TB + 32'h8, STATUS = TB + 32'hC;
  typedef struct {
    string       name;
    logic        we, re;
    logic [31:0] addr, wdata;
    logic [2:0]  size;
    logic        chk;
    logic [31:0] data;
    logic        err, ichk, irq;
  } step_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0, total = 0;
  step_t sb[$];
  bus_data_responder_if bus();
  bus_data_responder dut (.clk(clk), .reset(reset), .bus(bus));
  always #10 clk = ~clk;
  task automatic push(input string n, input logic we, re, input logic [31:0] addr, wdata,
                      input logic [2:0] size, input logic chk, input logic [31:0] data,
                      input logic err, ichk, irq);
    step_t s;
    s.name = n; s.we = we; s.re = re; s.addr = addr; s.wdata = wdata; s.size = size;
    s.chk = chk; s.data = data; s.err = err; s.ichk = ichk; s.irq = irq;
    sb.push_back(s);
  endtask
  task automatic wr(input logic [31:0] addr, data, input logic [2:0] size);
    push("wr", 1'b1, 1'b0, addr, data, size, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic rd(input string n, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    push(n, 1'b0, 1'b1, addr, 32'd0, size, 1'b1, data, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic rdi(input string n, input logic [31:0] addr, data, input logic irq);
    push(n, 1'b0, 1'b1, addr, 32'd0, 3'b010, 1'b1, data, 1'b0, 1'b1, irq);
  endtask
  task automatic flt(input string n, input logic we, input logic [31:0] addr, input logic [2:0] size);
    push(n, we, !we, addr, 32'h1234_5678, size, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic drive(input step_t s);
    @(negedge clk);
    bus.busWe = s.we; bus.busRe = s.re; bus.busAddr = s.addr; bus.busWData = s.wdata; bus.busSize = s.size;
    #1;
  endtask
  task automatic test_reset();
    step_t s;
    rdi("rst_ctrl", CTRL, 32'd0, 1'b0);
    rdi("rst_count", COUNT, 32'd0, 1'b0);
    rdi("rst_cmp", CMP, 32'd0, 1'b0);
    rdi("rst_status", STATUS, 32'd0, 1'b0);
    while (sb.size() != 0) begin
      s = sb.pop_front(); drive(s);
      if (s.chk) begin
        total++;
        if (bus.busRData !== s.data || bus.busErr !== s.err || (s.ichk && bus.timerIrq !== s.irq))
          $display("FAIL %s: rdata=%h err=%b irq=%b, expected rdata=%h err=%b irq=%b", s.name, bus.busRData, bus.busErr, bus.timerIrq, s.data, s.err, s.irq);
        else passed++;
      end
    end
    reset = 1'b0;
  endtask
  task automatic test_ram();
    step_t s;
    wr(32'h10, 32'hDEAD_BEEF, 3'b010);
    wr(32'h11, 32'h0000_0055, 3'b000);
    rd("lw_10", 32'h10, 3'b010, 32'hDEAD_55EF);
    rd("lb_13", 32'h13, 3'b000, 32'hFFFF_FFDE);
    rd("lbu_13", 32'h13, 3'b100, 32'h0000_00DE);
    rd("lh_12", 32'h12, 3'b001, 32'hFFFF_DEAD);
    rd("lhu_12", 32'h12, 3'b101, 32'h0000_DEAD);
    rd("lh_10", 32'h10, 3'b001, 32'h0000_55EF);
    rd("lb_11", 32'h11, 3'b000, 32'h0000_0055);
    push("no_re", 1'b0, 1'b0, 32'h10, 32'd0, 3'b010, 1'b1, 32'hDEAD_55EF, 1'b0, 1'b0, 1'b0);
    wr(32'h3FC, 32'hA5A5_0001, 3'b010);
    rd("lw_top", 32'h3FC, 3'b010, 32'hA5A5_0001);
    while (sb.size() != 0) begin
      s = sb.pop_front(); drive(s);
      if (s.chk) begin
        total++;
        if (bus.busRData !== s.data || bus.busErr !== s.err || (s.ichk && bus.timerIrq !== s.irq))
          $display("FAIL %s: rdata=%h err=%b irq=%b, expected rdata=%h err=%b irq=%b", s.name, bus.busRData, bus.busErr, bus.timerIrq, s.data, s.err, s.irq);
        else passed++;
      end
    end
  endtask
  task automatic test_faults();
    step_t s;
    flt("sw_misal", 1'b1, 32'h12, 3'b010);
    flt("sh_misal", 1'b1, 32'h13, 3'b001);
    flt("lw_unmap", 1'b0, 32'h2000_0000, 3'b010);
    flt("lw_past_ram", 1'b0, 32'h400, 3'b010);
    flt("sz_011", 1'b0, 32'h10, 3'b011);
    flt("sz_110_wr", 1'b1, 32'h10, 3'b110);
    flt("tmr_byte", 1'b0, CTRL, 3'b000);
    flt("tmr_off10", 1'b1, TB + 32'h10, 3'b010);
    rd("lw_kept", 32'h10, 3'b010, 32'hDEAD_55EF);
    rdi("ctrl_kept", CTRL, 32'd0, 1'b0);
    while (sb.size() != 0) begin
      s = sb.pop_front(); drive(s);
      if (s.chk) begin
        total++;
        if (bus.busRData !== s.data || bus.busErr !== s.err || (s.ichk && bus.timerIrq !== s.irq))
          $display("FAIL %s: rdata=%h err=%b irq=%b, expected rdata=%h err=%b irq=%b", s.name, bus.busRData, bus.busErr, bus.timerIrq, s.data, s.err, s.irq);
        else passed++;
      end
    end
  endtask
  task automatic test_match();
    step_t s;
    wr(CMP, 32'd5, 3'b010);
    wr(CTRL, 32'h7, 3'b010);
    for (int i = 0; i < 5; i++) rdi("cnt_up", COUNT, 32'(i), 1'b0);
    rdi("cnt_eq5", COUNT, 32'd5, 1'b0);
    rdi("cnt_reload", COUNT, 32'd0, 1'b1);
    rdi("status_set", STATUS, 32'd1, 1'b1);
    wr(STATUS, 32'd1, 3'b010);
    rdi("status_w1c", STATUS, 32'd0, 1'b0);
    wr(CTRL, 32'd0, 3'b010);
    while (sb.size() != 0) begin
      s = sb.pop_front(); drive(s);
      if (s.chk) begin
        total++;
        if (bus.busRData !== s.data || bus.busErr !== s.err || (s.ichk && bus.timerIrq !== s.irq))
          $display("FAIL %s: rdata=%h err=%b irq=%b, expected rdata=%h err=%b irq=%b", s.name, bus.busRData, bus.busErr, bus.timerIrq, s.data, s.err, s.irq);
        else passed++;
      end
    end
  endtask
  task automatic test_wrap();
    step_t s;
    wr(COUNT, 32'hFFFF_FFFE, 3'b010);
    wr(CTRL, 32'd1, 3'b010);
    rdi("wrap_fe", COUNT, 32'hFFFF_FFFE, 1'b0);
    rdi("wrap_ff", COUNT, 32'hFFFF_FFFF, 1'b0);
    rdi("wrap_0", COUNT, 32'd0, 1'b0);
    rdi("wrap_nomatch", STATUS, 32'd0, 1'b0);
    while (sb.size() != 0) begin
      s = sb.pop_front(); drive(s);
      if (s.chk) begin
        total++;
        if (bus.busRData !== s.data || bus.busErr !== s.err || (s.ichk && bus.timerIrq !== s.irq))
          $display("FAIL %s: rdata=%h err=%b irq=%b, expected rdata=%h err=%b irq=%b", s.name, bus.busRData, bus.busErr, bus.timerIrq, s.data, s.err, s.irq);
        else passed++;
      end
    end
  endtask
  task automatic test_simultaneous();
    step_t s;
    wr(COUNT, 32'd100, 3'b010);
    rdi("cnt_wr_wins", COUNT, 32'd100, 1'b0);
    rdi("cnt_after_wr", COUNT, 32'd101, 1'b0);
    wr(COUNT, 32'd5, 3'b010);
    wr(STATUS, 32'd1, 3'b010);
    rdi("set_beats_w1c", STATUS, 32'd1, 1'b0);
    wr(STATUS, 32'd1, 3'b010);
    rdi("w1c_clear", STATUS, 32'd0, 1'b0);
    wr(COUNT, 32'd5, 3'b010);
    wr(COUNT, 32'd200, 3'b010);
    rdi("match_prewrite", STATUS, 32'd1, 1'b0);
    rdi("cnt_200_inc", COUNT, 32'd201, 1'b0);
    while (sb.size() != 0) begin
      s = sb.pop_front(); drive(s);
      if (s.chk) begin
        total++;
        if (bus.busRData !== s.data || bus.busErr !== s.err || (s.ichk && bus.timerIrq !== s.irq))
          $display("FAIL %s: rdata=%h err=%b irq=%b, expected rdata=%h err=%b irq=%b", s.name, bus.busRData, bus.busErr, bus.timerIrq, s.data, s.err, s.irq);
        else passed++;
      end
    end
  endtask
  task automatic test_async_reset();
    step_t s;
    wr(CTRL, 32'h7, 3'b010);
    wr(COUNT, 32'd37, 3'b010);
    rdi("pre_rst_cnt", COUNT, 32'd37, 1'b1);
    while (sb.size() != 0) begin
      s = sb.pop_front(); drive(s);
      if (s.chk) begin
        total++;
        if (bus.busRData !== s.data || bus.busErr !== s.err || (s.ichk && bus.timerIrq !== s.irq))
          $display("FAIL %s: rdata=%h err=%b irq=%b, expected rdata=%h err=%b irq=%b", s.name, bus.busRData, bus.busErr, bus.timerIrq, s.data, s.err, s.irq);
        else passed++;
      end
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.busRData !== 32'd0 || bus.timerIrq !== 1'b0)
      $display("FAIL async_rst_cnt: rdata=%h irq=%b, expected rdata=00000000 irq=0", bus.busRData, bus.timerIrq);
    else passed++;
    bus.busAddr = CTRL;
    #1;
    total++;
    if (bus.busRData !== 32'd0) $display("FAIL async_rst_ctrl: rdata=%h, expected 00000000", bus.busRData);
    else passed++;
    #1 reset = 1'b0;
    rd("ram_retained", 32'h10, 3'b010, 32'hDEAD_55EF);
    rdi("cnt_stopped", COUNT, 32'd0, 1'b0);
    while (sb.size() != 0) begin
      s = sb.pop_front(); drive(s);
      if (s.chk) begin
        total++;
        if (bus.busRData !== s.data || bus.busErr !== s.err || (s.ichk && bus.timerIrq !== s.irq))
          $display("FAIL %s: rdata=%h err=%b irq=%b, expected rdata=%h err=%b irq=%b", s.name, bus.busRData, bus.busErr, bus.timerIrq, s.data, s.err, s.irq);
        else passed++;
      end
    end
  endtask
  initial begin
    bus.busWe = 1'b0; bus.busRe = 1'b0; bus.busAddr = 32'd0; bus.busWData = 32'd0; bus.busSize = 3'b010;
    test_reset();
    test_ram();
    test_faults();
    test_match();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, expected completion before 200000");
    $fatal(1);
  end
endmodule

// File: doc/bus_data_responder.md
Name: bus_data_responder

Overview:
Bus responder (data memory plus timer peripheral) for the single-cycle RV32I core's data bus. It answers the core's busAddr/busWData/busRData accesses from the other end of the interface. It decodes the address into a word-organised data RAM region and a memory-mapped timer register region. Reads are combinational to fit the single-cycle core. Writes and timer state update on the clock edge.

Parameters:
RAM_WORDS, 256, data RAM depth in 32-bit words; power of 2; RAM occupies 0x0 to RAM_WORDS*4-1.
TIMER_BASE, 32'h1000_0000, base address of the timer register block (16-byte aligned).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
busWe  input  1  store strobe; a write commits at posedge clk.
busRe  input  1  load strobe; qualifies busErr for reads.
busSize  input  3  access type = instruction funct3: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
busAddr  input  32  byte address from the ALU result.
busWData  input  32  store data, right-aligned.
busRData  output  32  load data, extended per busSize.
busErr  output  1  access fault (misaligned, unmapped, or illegal size).
timerIrq  output  1  level interrupt = STATUS.match & CTRL.irqEn.

Behaviour:
- Reset (async, highest priority):
  - CTRL, COUNT, CMP and STATUS clear to 0; timerIrq=0.
  - RAM contents are not reset.
  - Reset asserted mid-count stops and clears the counter immediately.
- Decode:
  - RAM hit: busAddr < RAM_WORDS*4.
  - Timer hit: busAddr[31:4]==TIMER_BASE[31:4].
  - Anything else is unmapped.
- Alignment:
  - Half access requires addr[0]=0; word access requires addr[1:0]=0.
  - Otherwise the access is misaligned.
- busErr = (busWe|busRe) & (misaligned | unmapped | timer access with busSize!=010 | busSize in {011,110,111}).
  - On a fault, busRData=0 and any write is suppressed.
- RAM read (combinational):
  - Select the byte or half by addr[1:0].
  - Sizes 000/001 sign-extend; 100/101 zero-extend; 010 returns the full word.
  - With busRe=0, busRData still shows the decoded read (no side effects).
- RAM write (posedge, busWe & !busErr):
  - Byte/half/word writes update only the addressed byte lanes; other lanes keep their value.
  - busWData[7:0] / [15:0] are steered to the lane selected by addr[1:0].
- Timer registers (word offset from TIMER_BASE):
  - 0x0 CTRL, R/W, bits[2:0]: bit0 enable, bit1 autoReload, bit2 irqEn; other bits read 0.
  - 0x4 COUNT, R/W, 32 bits.
  - 0x8 CMP, R/W, 32 bits.
  - 0xC STATUS, bit0 match; write-1-to-clear; writing 0 has no effect.
- Counter, each posedge while enable=1:
  - If COUNT==CMP: match is set; COUNT becomes 0 if autoReload=1, else COUNT+1.
  - Otherwise COUNT becomes COUNT+1.
  - 32'hFFFF_FFFF wraps to 0 without setting match, unless CMP==FFFF_FFFF.
- Simultaneous events:
  - A CPU write to COUNT in the same cycle as an increment: the write wins (COUNT=busWData, no increment that cycle).
  - A match is still evaluated on the pre-write COUNT.
  - W1C of match in the same cycle as a new match: set wins (match stays 1).
  - A write to CMP takes effect for the next cycle's comparison.
- Timer reads show the register value before the current edge's update (same-cycle read-after-write returns the old value).

Optional Feature:
TIMER_PRESCALE_EN:
- Defined: adds a PRESC register at offset 0x10 (R/W, 16 bits, resets to 0) and an internal prescale counter.
  - COUNT advances only when the prescale counter equals PRESC; the prescale counter then returns to 0.
  - PRESC=0 means every cycle.
  - Writing CTRL.enable=0 clears the prescale counter.
- Undefined: offset 0x10 is unmapped (busErr=1, reads 0) and COUNT advances every enabled cycle.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then byte store 0x55 to 0x11 -> lw 0x10 reads 0xDEAD55EF; lb 0x13 reads 0xFFFFFFDE; lbu 0x13 reads 0x000000DE; lh 0x12 reads 0xFFFFDEAD.
- Misaligned/unmapped: sw to 0x12 and lw from 0x2000_0000 -> busErr=1, busRData=0, RAM word 0x10 unchanged.
- CMP=5, CTRL=0b111 -> match and timerIrq rise on the edge where COUNT==5; COUNT=0 next; W1C on STATUS drops timerIrq the next cycle.
- CTRL=0b001, COUNT written to 0xFFFF_FFFE -> counts 0xFFFF_FFFF, then 0x0; match stays 0 while CMP=5.
- Write COUNT=100 in the same cycle the counter would increment -> COUNT=100 next cycle; W1C coinciding with a new match -> match stays 1.
- Assert reset mid-count (COUNT=37, enabled) asynchronously between edges -> COUNT=0, CTRL=0, timerIrq=0 immediately; RAM data retained.
